dma_engine: RTL and testbench



---
 rtl/dma_defs.sv | 27 ++
 rtl/dma_engine.sv | 156 +++++++++++++++
 tb/tb_dma_engine.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_defs.sv
// dma_defs: register map, CTRL bit positions and FSM encoding shared by the DMA engine.
package dma_defs;
    localparam logic [3:0] REG_SRC  = 4'h0;
    localparam logic [3:0] REG_DST  = 4'h4;
    localparam logic [3:0] REG_LEN  = 4'h8;
    localparam logic [3:0] REG_CTRL = 4'hC;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_DONE   = 2;
    localparam int CTRL_BUSY   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP_W,
        ST_WR,
        ST_GAP_R
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dma_engine.sv
// dma_engine: word-granular memory-to-memory copier with a register responder port and a valid/ready initiator port.
module dma_engine
    import dma_defs::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        irq
);
    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [31:0]          data_o_q, data_o_d;
    logic [31:0]          src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, rem_q, rem_d;
    logic [31:0]          cur_src_q, cur_src_d, cur_dst_q, cur_dst_d, buf_q, buf_d;
    logic                 irq_en_q, irq_en_d, done_q, done_d, zero_q, zero_d;
    logic                 m_valid_q, m_valid_d;
    logic [31:0]          m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [3:0]           m_wstrb_q, m_wstrb_d;
    logic                 access, wr, busy, ctrl_wr, start, finish;
    logic [3:0]           word;
    logic [31:0]          len_m, rdata;

    assign access  = select & ~ready_q;
    assign wr      = access & |wstrb;
    assign word    = {addr[3:2], 2'b00};
    assign busy    = state_q != ST_IDLE;
    assign ctrl_wr = wr && word == REG_CTRL && wstrb[0];
    assign start   = ctrl_wr && data_i[CTRL_START] && !busy;
    assign len_m   = merge_bytes(32'(len_q), data_i, wstrb);
    assign rdata   = word == REG_SRC ? src_q :
                     word == REG_DST ? dst_q :
                     word == REG_LEN ? 32'(len_q) :
                     {28'd0, busy, done_q, irq_en_q, 1'b0};

    always_comb begin
        ready_d   = access;
        data_o_d  = access ? rdata : data_o_q;
        src_d     = (wr && word == REG_SRC && !busy) ? merge_bytes(src_q, data_i, wstrb) : src_q;
        dst_d     = (wr && word == REG_DST && !busy) ? merge_bytes(dst_q, data_i, wstrb) : dst_q;
        len_d     = (wr && word == REG_LEN && !busy) ? len_m[LEN_WIDTH-1:0] : len_q;
        irq_en_d  = ctrl_wr ? data_i[CTRL_IRQ_EN] : irq_en_q;
        zero_d    = start && len_q == '0;
        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        buf_d     = buf_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: if (start && len_q != '0) begin
                state_d   = ST_RD;
                cur_src_d = {src_q[31:2], 2'b00};
                cur_dst_d = {dst_q[31:2], 2'b00};
                rem_d     = len_q;
                m_valid_d = 1'b1;
                m_addr_d  = {src_q[31:2], 2'b00};
                m_wstrb_d = 4'h0;
            end
            ST_RD: if (m_ready) begin
                state_d   = ST_GAP_W;
                buf_d     = m_rdata;
                m_valid_d = 1'b0;
            end
            ST_GAP_W: begin
                state_d   = ST_WR;
                m_valid_d = 1'b1;
                m_addr_d  = cur_dst_q;
                m_wdata_d = buf_q;
                m_wstrb_d = 4'hF;
            end
            ST_WR: if (m_ready) begin
                cur_src_d = cur_src_q + 32'd4;
                cur_dst_d = cur_dst_q + 32'd4;
                rem_d     = rem_q - 1'b1;
                m_valid_d = 1'b0;
                finish    = rem_q == LEN_WIDTH'(1);
                state_d   = finish ? ST_IDLE : ST_GAP_R;
            end
            ST_GAP_R: begin
                state_d   = ST_RD;
                m_valid_d = 1'b1;
                m_addr_d  = cur_src_q;
                m_wstrb_d = 4'h0;
            end
            default: state_d = ST_IDLE;
        endcase
        // a clear and a completion in the same cycle leave done set
        done_d = (done_q & ~(ctrl_wr & data_i[CTRL_DONE])) | finish | zero_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            data_o_q  <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            buf_q     <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            data_o_q  <= data_o_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            buf_q     <= buf_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
        end
    end

    assign ready   = ready_q;
    assign data_o  = data_o_q;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign irq     = done_q & irq_en_q;
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed scenarios against a behavioural memory responder with configurable wait states.
module tb_dma_engine;
    logic        clk = 1'b0, reset_n = 1'b0, select = 1'b0;
    logic [3:0]  wstrb = '0, addr = '0;
    logic [31:0] data_i = '0;
    logic        ready, m_valid, irq, m_ready;
    logic [31:0] data_o, m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    int cmp = 0, err = 0;

    dma_engine #(.LEN_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .select(select), .wstrb(wstrb), .addr(addr),
        .data_i(data_i), .ready(ready), .data_o(data_o), .m_valid(m_valid), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [31:0] src_mem [256];
    int waits = 0, wcnt = 0;
    always_comb m_ready = m_valid && (wcnt >= waits);
    always_comb m_rdata = src_mem[m_addr[9:2]];
    always @(posedge clk or negedge reset_n)
        if (!reset_n) wcnt <= 0;
        else wcnt <= (m_valid && !m_ready) ? wcnt + 1 : 0;

    logic        log_w [64];
    logic [31:0] log_a [64], log_d [64];
    int hs = 0;
    always @(posedge clk)
        if (reset_n && m_valid && m_ready) begin
            log_w[hs] <= (m_wstrb == 4'hF);
            log_a[hs] <= m_addr;
            log_d[hs] <= (m_wstrb == 4'hF) ? m_wdata : m_rdata;
            hs <= hs + 1;
        end

    logic        hold = 1'b0;
    logic [31:0] s_a, s_d;
    logic [3:0]  s_s;
    int unstable = 0, wait_cycles = 0;
    always @(posedge clk) begin
        hold <= reset_n && m_valid && !m_ready;
        s_a  <= m_addr;
        s_d  <= m_wdata;
        s_s  <= m_wstrb;
        if (reset_n && m_valid && !m_ready) wait_cycles <= wait_cycles + 1;
    end
    always @(negedge clk)
        if (hold && (!m_valid || m_addr !== s_a || m_wdata !== s_d || m_wstrb !== s_s))
            unstable <= unstable + 1;

    task automatic bus_xfer(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] q);
        int n;
        @(negedge clk);
        select = 1'b1; addr = a; data_i = d; wstrb = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 20);
        if (!ready) begin
            cmp++; err++;
            $display("FAIL bus_timeout addr=%h: ready never rose within 20 cycles", a);
        end
        q = data_o;
        select = 1'b0; wstrb = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_xfer(a, d, 4'hF, q);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] q);
        bus_xfer(a, 32'd0, 4'h0, q);
    endtask

    task automatic wait_irq(output int cyc);
        cyc = 0;
        while (!irq && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (!irq) begin
            cmp++; err++;
            $display("FAIL irq_timeout: irq still 0 after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        logic [31:0] q;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cmp++;
        if ({ready, m_valid, irq, m_wstrb} !== 7'd0 || data_o !== 0 || m_addr !== 0 || m_wdata !== 0) begin
            err++;
            $display("FAIL reset_outputs: ready=%b m_valid=%b irq=%b m_wstrb=%h data_o=%h m_addr=%h m_wdata=%h, want all 0",
                     ready, m_valid, irq, m_wstrb, data_o, m_addr, m_wdata);
        end
        waits = 1000;
        wr(4'h0, 32'h0002_0000);
        wr(4'h4, 32'h0002_0100);
        wr(4'h8, 32'd5);
        wr(4'hC, 32'h3);
        @(negedge clk);
        cmp++;
        if (m_valid !== 1'b1) begin err++; $display("FAIL mid_rd_valid: m_valid=%b want 1", m_valid); end
        #2 reset_n = 1'b0;
        #1;
        cmp++;
        if (m_valid !== 1'b0) begin err++; $display("FAIL async_reset_valid: m_valid=%b want 0", m_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        waits = 0;
        for (int i = 0; i < 4; i++) begin
            rd(4'(4 * i), q);
            cmp++;
            if (q !== 32'd0) begin err++; $display("FAIL reset_reg%0d: read %h want 00000000", i, q); end
        end
        cmp++;
        if (irq !== 1'b0) begin err++; $display("FAIL reset_irq: irq=%b want 0", irq); end
    endtask

    task automatic test_regs();
        logic [31:0] q;
        wr(4'h0, 32'h1122_3344);
        bus_xfer(4'h0, 32'hAABB_CCDD, 4'b0101, q);
        rd(4'h0, q);
        cmp++;
        if (q !== 32'h11BB_33DD) begin err++; $display("FAIL byte_strobe: SRC=%h want 11bb33dd", q); end
        wr(4'h8, 32'hFFFF_1234);
        rd(4'h8, q);
        cmp++;
        if (q !== 32'h0000_1234) begin err++; $display("FAIL len_width: LEN=%h want 00001234", q); end
        bus_xfer(4'hE, 32'h2, 4'h1, q);
        rd(4'hD, q);
        cmp++;
        if (q !== 32'h2) begin err++; $display("FAIL ctrl_alias: CTRL@0xD=%h want 00000002", q); end
        wr(4'hC, 32'h0);
        @(negedge clk);
        select = 1'b1; addr = 4'h4; wstrb = 4'h0;
        @(negedge clk);
        cmp++;
        if (ready !== 1'b1) begin err++; $display("FAIL b2b_first: ready=%b want 1", ready); end
        @(negedge clk);
        cmp++;
        if (ready !== 1'b0) begin err++; $display("FAIL b2b_gap: ready=%b want 0", ready); end
        @(negedge clk);
        cmp++;
        if (ready !== 1'b1) begin err++; $display("FAIL b2b_second: ready=%b want 1", ready); end
        select = 1'b0;
    endtask

    task automatic test_copy3();
        int base;
        logic [31:0] q;
        src_mem[0] = 32'h1111_1111; src_mem[1] = 32'h2222_2222; src_mem[2] = 32'h3333_3333;
        wr(4'h0, 32'h0002_0000);
        wr(4'h4, 32'h0002_0100);
        wr(4'h8, 32'd3);
        base = hs;
        wr(4'hC, 32'h3);
        repeat (10) @(negedge clk);
        cmp++;
        if (irq !== 1'b0) begin err++; $display("FAIL copy3_early: irq=%b want 0 before final handshake", irq); end
        @(negedge clk);
        cmp++;
        if (irq !== 1'b1) begin err++; $display("FAIL copy3_irq: irq=%b want 1 after final handshake", irq); end
        cmp++;
        if (hs - base !== 6) begin err++; $display("FAIL copy3_count: handshakes=%0d want 6", hs - base); end
        for (int k = 0; k < 3; k++) begin
            cmp++;
            if (log_w[base+2*k] !== 1'b0 || log_a[base+2*k] !== 32'h0002_0000 + 32'(4*k)) begin
                err++;
                $display("FAIL copy3_rd%0d: write=%b addr=%h want read at %h", k, log_w[base+2*k],
                         log_a[base+2*k], 32'h0002_0000 + 32'(4*k));
            end
            cmp++;
            if (log_w[base+2*k+1] !== 1'b1 || log_a[base+2*k+1] !== 32'h0002_0100 + 32'(4*k) ||
                log_d[base+2*k+1] !== src_mem[k]) begin
                err++;
                $display("FAIL copy3_wr%0d: write=%b addr=%h data=%h want write %h at %h", k,
                         log_w[base+2*k+1], log_a[base+2*k+1], log_d[base+2*k+1], src_mem[k],
                         32'h0002_0100 + 32'(4*k));
            end
        end
        rd(4'hC, q);
        cmp++;
        if (q !== 32'h6) begin err++; $display("FAIL copy3_stat: CTRL=%h want 00000006", q); end
    endtask

    task automatic test_wait_states();
        int base, u0, w0, cyc;
        waits = 3;
        src_mem[0] = 32'hAAAA_5555; src_mem[1] = 32'h5A5A_0F0F;
        wr(4'h0, 32'h0002_0000);
        wr(4'h4, 32'h0002_0200);
        wr(4'h8, 32'd2);
        base = hs; u0 = unstable; w0 = wait_cycles;
        wr(4'hC, 32'h7);
        cmp++;
        if (irq !== 1'b0) begin err++; $display("FAIL start_clear_irq: irq=%b want 0", irq); end
        wait_irq(cyc);
        cmp++;
        if (cyc !== 19) begin err++; $display("FAIL wait_latency: cycles=%0d want 19", cyc); end
        cmp++;
        if (wait_cycles - w0 !== 12) begin err++; $display("FAIL wait_count: waits=%0d want 12", wait_cycles - w0); end
        cmp++;
        if (unstable !== u0) begin err++; $display("FAIL wait_stable: changes=%0d want 0", unstable - u0); end
        cmp++;
        if (hs - base !== 4 || log_a[base+1] !== 32'h0002_0200 || log_d[base+1] !== 32'hAAAA_5555 ||
            log_a[base+3] !== 32'h0002_0204 || log_d[base+3] !== 32'h5A5A_0F0F) begin
            err++;
            $display("FAIL wait_data: n=%0d w0=%h@%h w1=%h@%h want aaaa5555@00020200 5a5a0f0f@00020204",
                     hs - base, log_d[base+1], log_a[base+1], log_d[base+3], log_a[base+3]);
        end
        waits = 0;
    endtask

    task automatic test_len_zero();
        int base;
        logic seen;
        logic [31:0] q;
        wr(4'h8, 32'd0);
        wr(4'hC, 32'h6);
        base = hs;
        seen = 1'b0;
        wr(4'hC, 32'h3);
        cmp++;
        if (irq !== 1'b0) begin err++; $display("FAIL len0_ready_irq: irq=%b want 0", irq); end
        @(negedge clk);
        cmp++;
        if (irq !== 1'b1) begin err++; $display("FAIL len0_irq: irq=%b want 1", irq); end
        repeat (5) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        cmp++;
        if (seen !== 1'b0 || hs !== base) begin err++; $display("FAIL len0_no_valid: m_valid seen=%b handshakes=%0d want 0", seen, hs - base); end
        rd(4'hC, q);
        cmp++;
        if (q !== 32'h6) begin err++; $display("FAIL len0_stat: CTRL=%h want 00000006", q); end
    endtask

    task automatic test_busy();
        int base, cyc;
        logic [31:0] q;
        for (int i = 0; i < 4; i++) src_mem[i] = 32'hC0DE_0000 + 32'(i);
        wr(4'hC, 32'h6);
        wr(4'h0, 32'h0002_0000);
        wr(4'h4, 32'h0002_0300);
        wr(4'h8, 32'd4);
        base = hs;
        wr(4'hC, 32'h3);
        wr(4'h0, 32'hDEAD_0000);
        wr(4'hC, 32'h3);
        rd(4'hC, q);
        cmp++;
        if (q !== 32'hA) begin err++; $display("FAIL busy_stat: CTRL=%h want 0000000a", q); end
        rd(4'h0, q);
        cmp++;
        if (q !== 32'h0002_0000) begin err++; $display("FAIL busy_src: SRC=%h want 00020000", q); end
        wait_irq(cyc);
        repeat (6) @(negedge clk);
        cmp++;
        if (hs - base !== 8 || log_a[base+6] !== 32'h0002_000C || log_d[base+7] !== 32'hC0DE_0003) begin
            err++;
            $display("FAIL busy_count: handshakes=%0d last_rd=%h last_wd=%h want 8 0002000c c0de0003",
                     hs - base, log_a[base+6], log_d[base+7]);
        end
    endtask

    task automatic test_wrap_clear();
        int base, cyc;
        logic [31:0] q;
        src_mem[255] = 32'hCAFE_F00D; src_mem[0] = 32'h0BAD_BEEF;
        wr(4'hC, 32'h6);
        wr(4'h0, 32'hFFFF_FFFC);
        wr(4'h4, 32'h0000_0100);
        wr(4'h8, 32'd2);
        base = hs;
        wr(4'hC, 32'h3);
        wait_irq(cyc);
        cmp++;
        if (log_a[base] !== 32'hFFFF_FFFC || log_a[base+2] !== 32'h0 || log_d[base+3] !== 32'h0BAD_BEEF) begin
            err++;
            $display("FAIL wrap_addr: rd0=%h rd1=%h wd1=%h want fffffffc 00000000 0badbeef",
                     log_a[base], log_a[base+2], log_d[base+3]);
        end
        cmp++;
        if (irq !== 1'b1) begin err++; $display("FAIL wrap_irq: irq=%b want 1", irq); end
        wr(4'hC, 32'h4);
        cmp++;
        if (irq !== 1'b0) begin err++; $display("FAIL clear_irq: irq=%b want 0", irq); end
        rd(4'hC, q);
        cmp++;
        if (q !== 32'h0) begin err++; $display("FAIL clear_stat: CTRL=%h want 00000000", q); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) src_mem[i] = 32'd0;
        test_reset();
        test_regs();
        test_copy3();
        test_wait_states();
        test_len_zero();
        test_busy();
        test_wrap_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
